// File: rtl/fetch_pkg.sv
// Shared constants and types for the fetch stage: widths, instruction
// field positions, opcode encodings and the fetch state enum.
package fetch_pkg;

   localparam int ADDR_W  = 8;
   localparam int INSTR_W = 18;

   // Instruction format: {rs1[4:0], rs2[4:0], rd[4:0], op[2:0]}
   localparam int RS1_MSB = 17;
   localparam int RS1_LSB = 13;
   localparam int RS2_MSB = 12;
   localparam int RS2_LSB = 8;
   localparam int RD_MSB  = 7;
   localparam int RD_LSB  = 3;
   localparam int OP_MSB  = 2;
   localparam int OP_LSB  = 0;

   localparam logic [2:0] OP_SUMA = 3'b000;
   localparam logic [2:0] OP_AND  = 3'b001;
   localparam logic [2:0] OP_OR   = 3'b010;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/fetch_pc_ir_pc_counter.sv
// Program counter register. A load (redirect) wins over increment;
// with neither enable the PC holds. Increment wraps modulo 2^ADDR_W.
module pc_counter
   import fetch_pkg::*;
(
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_load,
   input  logic [ADDR_W-1:0] i_load_val,
   input  logic              i_inc,
   output logic [ADDR_W-1:0] o_pc
);

   logic [ADDR_W-1:0] r_pc;

   // PC update: redirect load, else increment, else hold
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_pc <= '0;
      end else if (i_load) begin
         r_pc <= i_load_val;
      end else if (i_inc) begin
         r_pc <= r_pc + ADDR_W'(1);
      end
   end

   assign o_pc = r_pc;

endmodule

// File: rtl/fetch_pc_ir.sv
// Fetch stage: owns the PC, drives the combinational instruction memory,
// captures the returned word into the IF/ID instruction register and
// splits it into decode fields.
//
// Handshake to decode: ir_valid/ir_ready. A transfer happens on a rising
// edge where ir_valid && ir_ready. ir_valid, once high, stays high with IR
// and pc_ir stable until the transfer, except that a redirect (salto_en)
// flushes it. ir_valid does not depend on ir_ready combinationally.
//
// Optional build macro: FETCH_COUNT_EN adds the n_instr load counter.
module fetch_pc_ir
   import fetch_pkg::*;
#(
   parameter logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(5)
)
(
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               salto_en,
   input  logic [ADDR_W-1:0]  salto_addr,
   output logic [ADDR_W-1:0]  addr,
   input  logic [INSTR_W-1:0] instruccion,
   output logic               ir_valid,
   input  logic               ir_ready,
   output logic [4:0]         rs1,
   output logic [4:0]         rs2,
   output logic [4:0]         rd,
   output logic [2:0]         op,
   output logic [ADDR_W-1:0]  pc_ir,
   output state_t             o_dbg_state,
   output logic               done
`ifdef FETCH_COUNT_EN
   ,
   output logic [15:0]        n_instr
`endif
);

   state_t             r_state;
   logic [INSTR_W-1:0] r_ir;
   logic [ADDR_W-1:0]  r_pc_ir;
   logic               r_ir_valid;
   logic               r_done;

   logic [ADDR_W-1:0]  w_pc;
   logic               w_redirect;
   logic               w_load;
   logic               w_inc;

   // Redirect is only honoured once fetching has started; it pre-empts any load.
   assign w_redirect = salto_en && (r_state != IDLE);
   assign w_load     = (r_state == FETCH) && (!r_ir_valid || ir_ready) && !w_redirect;
   // The PC parks on LAST_ADDR; the state machine moves to DONE instead.
   assign w_inc      = w_load && (w_pc != LAST_ADDR);

   pc_counter u_pc (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_load     (w_redirect),
      .i_load_val (salto_addr),
      .i_inc      (w_inc),
      .o_pc       (w_pc)
   );

   // Fetch state machine together with the IR, its valid flag and done
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= IDLE;
         r_ir       <= '0;
         r_pc_ir    <= '0;
         r_ir_valid <= 1'b0;
         r_done     <= 1'b0;
      end else if (w_redirect) begin
         r_state    <= FETCH;
         r_ir_valid <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         case (r_state)
            IDLE:    if (start) r_state <= FETCH;
            FETCH:   if (w_load && (w_pc == LAST_ADDR)) r_state <= DONE;
            DONE:    r_state <= DONE;
            default: r_state <= IDLE;
         endcase
         if (w_load) begin
            r_ir       <= instruccion;
            r_pc_ir    <= w_pc;
            r_ir_valid <= 1'b1;
         end else if (r_ir_valid && ir_ready) begin
            r_ir_valid <= 1'b0;
         end
         // DONE never loads, so the IR is empty next cycle unless it is held.
         r_done <= (r_state == DONE) && (!r_ir_valid || ir_ready);
      end
   end

`ifdef FETCH_COUNT_EN
   logic [15:0] r_n_instr;

   // Saturating count of IR loads; survives redirects
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_n_instr <= '0;
      end else if (w_load && (r_n_instr != 16'hFFFF)) begin
         r_n_instr <= r_n_instr + 16'd1;
      end
   end

   assign n_instr = r_n_instr;
`endif

   assign addr        = w_pc;
   assign ir_valid    = r_ir_valid;
   assign pc_ir       = r_pc_ir;
   assign done        = r_done;
   assign o_dbg_state = r_state;
   assign rs1         = r_ir[RS1_MSB:RS1_LSB];
   assign rs2         = r_ir[RS2_MSB:RS2_LSB];
   assign rd          = r_ir[RD_MSB:RD_LSB];
   assign op          = r_ir[OP_MSB:OP_LSB];

endmodule

// File: tb/tb_fetch_pc_ir.sv
// Testbench for fetch_pc_ir: directed scenarios with fixed expectations,
// then random backpressure/redirect traffic checked against a stream model
// (the ordered list of addresses decode should receive).
module tb_fetch_pc_ir;
   import fetch_pkg::*;

   localparam logic [7:0] LAST = 8'd5;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic         salto_en;
   logic [7:0]   salto_addr;
   logic [7:0]   addr;
   logic [17:0]  instruccion;
   logic         ir_valid;
   logic         ir_ready;
   logic [4:0]   rs1, rs2, rd;
   logic [2:0]   op;
   logic [7:0]   pc_ir;
   state_t       dbg_state;
   logic         done;
`ifdef FETCH_COUNT_EN
   logic [15:0]  n_instr;
`endif

   logic [17:0]  mem [0:255];

   int           n_checks = 0;
   int           n_errors = 0;

   // stream model: next address decode should see, and whether one is due
   logic [7:0]   m_next;
   logic         m_active;

   fetch_pc_ir dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .salto_en    (salto_en),
      .salto_addr  (salto_addr),
      .addr        (addr),
      .instruccion (instruccion),
      .ir_valid    (ir_valid),
      .ir_ready    (ir_ready),
      .rs1         (rs1),
      .rs2         (rs2),
      .rd          (rd),
      .op          (op),
      .pc_ir       (pc_ir),
      .o_dbg_state (dbg_state),
      .done        (done)
`ifdef FETCH_COUNT_EN
      ,
      .n_instr     (n_instr)
`endif
   );

   // combinational instruction memory
   assign instruccion = mem[addr];

   // clock
   always #5 clk = ~clk;

   // watchdog
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout required finish");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [17:0] pat(input int k);
      return {5'(3 * k), 5'(3 * k + 1), 5'(3 * k + 2), 3'(k % 3)};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst        = 1'b1;
      start      = 1'b0;
      salto_en   = 1'b0;
      salto_addr = 8'd0;
      ir_ready   = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic start_fetch();
      start    = 1'b1;
      ir_ready = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_pc(input logic [7:0] v);
      int n = 0;
      while (!(ir_valid && pc_ir == v) && n < 50) begin
         tick();
         n++;
      end
      check_eq("wait_pc_in_time", 32'(n < 50), 32'd1);
   endtask

   // one random-phase cycle; inputs driven just after an edge
   task automatic rnd_cycle(input logic rdy, input logic jmp, input logic [7:0] tgt);
      ir_ready   = rdy;
      salto_en   = jmp;
      salto_addr = tgt;
      #1;
      if (ir_valid && ir_ready) begin
         check_eq("stream_expected", 32'(m_active), 32'd1);
         check_eq("stream_pc", 32'(pc_ir), 32'(m_next));
         check_eq("stream_instr", 32'({rs1, rs2, rd, op}), 32'(mem[m_next]));
         if (m_next == LAST) m_active = 1'b0;
         else m_next = m_next + 8'd1;
      end
      if (jmp) begin
         m_next   = tgt;
         m_active = 1'b1;
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      int   n;
      logic rdy, jmp;
      logic [7:0] tgt;

      for (int i = 0; i < 256; i++) mem[i] = pat(i);

      // reset values, observed before any clock edge
      rst = 1'b1; start = 1'b0; salto_en = 1'b0; salto_addr = 8'd0; ir_ready = 1'b0;
      #1;
      check_eq("rst_addr", 32'(addr), 32'd0);
      check_eq("rst_valid", 32'(ir_valid), 32'd0);
      check_eq("rst_done", 32'(done), 32'd0);
      check_eq("rst_pc_ir", 32'(pc_ir), 32'd0);
      check_eq("rst_ir", 32'({rs1, rs2, rd, op}), 32'd0);
      check_eq("rst_state", 32'(dbg_state), 32'(IDLE));
      @(posedge clk);
      #1;
      rst = 1'b0;

      // redirect in IDLE is ignored
      salto_en = 1'b1; salto_addr = 8'd9;
      tick();
      salto_en = 1'b0;
      check_eq("idle_salto_state", 32'(dbg_state), 32'(IDLE));
      check_eq("idle_salto_addr", 32'(addr), 32'd0);

      // start and run to the end
      start_fetch();
      check_eq("start_state", 32'(dbg_state), 32'(FETCH));
      check_eq("start_addr", 32'(addr), 32'd0);
      check_eq("start_valid", 32'(ir_valid), 32'd0);
      tick();
      check_eq("ir0", 32'({rs1, rs2, rd, op}), 32'h00110);
      check_eq("ir0_pc", 32'(pc_ir), 32'd0);
      check_eq("ir0_valid", 32'(ir_valid), 32'd1);
      check_eq("ir0_rd", 32'(rd), 32'd2);
      tick();
      check_eq("ir1", 32'({rs1, rs2, rd, op}), 32'h06429);
      check_eq("ir1_pc", 32'(pc_ir), 32'd1);
      check_eq("ir1_op", 32'(op), 32'd1);
      for (int k = 2; k <= 5; k++) begin
         tick();
         check_eq("run_pc", 32'(pc_ir), 32'(k));
         check_eq("run_ir", 32'({rs1, rs2, rd, op}), 32'(pat(k)));
      end
      check_eq("last_state", 32'(dbg_state), 32'(DONE));
      check_eq("last_done", 32'(done), 32'd0);
      check_eq("last_addr", 32'(addr), 32'd5);
      tick();
      check_eq("drain_valid", 32'(ir_valid), 32'd0);
      check_eq("drain_done", 32'(done), 32'd1);
      check_eq("drain_addr", 32'(addr), 32'd5);
      tick();
      check_eq("done_hold", 32'(done), 32'd1);
      check_eq("done_addr_hold", 32'(addr), 32'd5);

      // backpressure
      do_reset();
      start_fetch();
      wait_pc(8'd2);
      ir_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         tick();
         check_eq("bp_pc_ir", 32'(pc_ir), 32'd2);
         check_eq("bp_addr", 32'(addr), 32'd3);
         check_eq("bp_valid", 32'(ir_valid), 32'd1);
         check_eq("bp_ir", 32'({rs1, rs2, rd, op}), 32'(pat(2)));
      end
      ir_ready = 1'b1;
      tick();
      check_eq("bp_release_pc", 32'(pc_ir), 32'd3);
      check_eq("bp_release_ir", 32'({rs1, rs2, rd, op}), 32'(pat(3)));

      // redirect from FETCH
      do_reset();
      start_fetch();
      wait_pc(8'd1);
      salto_en = 1'b1; salto_addr = 8'd4;
      tick();
      salto_en = 1'b0;
      check_eq("jmp_flush_valid", 32'(ir_valid), 32'd0);
      check_eq("jmp_addr", 32'(addr), 32'd4);
      tick();
      check_eq("jmp_valid", 32'(ir_valid), 32'd1);
      check_eq("jmp_pc_ir", 32'(pc_ir), 32'd4);
      check_eq("jmp_rs1", 32'(rs1), 32'd12);
      check_eq("jmp_rs2", 32'(rs2), 32'd13);
      check_eq("jmp_rd", 32'(rd), 32'd14);
      check_eq("jmp_op", 32'(op), 32'd1);
      tick();
      check_eq("jmp_next_pc", 32'(pc_ir), 32'd5);
      tick();
      check_eq("jmp_done", 32'(done), 32'd1);

      // redirect from DONE
      salto_en = 1'b1; salto_addr = 8'd0;
      tick();
      salto_en = 1'b0;
      check_eq("done_jmp_done", 32'(done), 32'd0);
      check_eq("done_jmp_state", 32'(dbg_state), 32'(FETCH));
      check_eq("done_jmp_valid", 32'(ir_valid), 32'd0);
      tick();
      check_eq("done_jmp_pc", 32'(pc_ir), 32'd0);
      check_eq("done_jmp_vld", 32'(ir_valid), 32'd1);

      // asynchronous reset between edges
      do_reset();
      start_fetch();
      wait_pc(8'd3);
      #2;
      rst = 1'b1;
      #1;
      check_eq("arst_valid", 32'(ir_valid), 32'd0);
      check_eq("arst_addr", 32'(addr), 32'd0);
      check_eq("arst_state", 32'(dbg_state), 32'(IDLE));
      @(posedge clk);
      #1;
      rst = 1'b0;

      // random traffic against the stream model
      do_reset();
      for (int i = 0; i < 256; i++) mem[i] = 18'($urandom);
      start_fetch();
      m_next   = 8'd0;
      m_active = 1'b1;
      for (int c = 0; c < 800; c++) begin
         rdy = ($urandom_range(0, 3) != 0);
         jmp = ($urandom_range(0, 39) == 0);
         if ($urandom_range(0, 3) == 0) tgt = 8'(250 + $urandom_range(0, 5));
         else tgt = 8'($urandom_range(0, 5));
         if (jmp) rdy = 1'b0;
         rnd_cycle(rdy, jmp, tgt);
      end
      n = 0;
      while (!done && n < 400) begin
         rnd_cycle(1'b1, 1'b0, 8'd0);
         n++;
      end
      check_eq("rnd_done", 32'(done), 32'd1);
      check_eq("rnd_stream_complete", 32'(m_active), 32'd0);
      check_eq("rnd_addr_parked", 32'(addr), 32'(LAST));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
